md_unit: RTL
============

// Module: md_unit
// PURPOSE
//   Execute-stage multiply/divide unit for the 5-stage MIPS pipeline: runs
//   mult/multu/div/divu over several cycles and owns the HI/LO registers.
//   Sits beside the ALU in E; its busy flag feeds the hazard/stall logic so
//   mfhi/mflo and new MD ops in D stall until the result commits. HI/LO
//   outputs are read by the E-stage result mux, like any other E value.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk        in   1   clock, rising edge
//   reset      in   1   async reset, active-low
//   md_start   in   1   op valid this cycle (E-stage instruction is MD op)
//   md_op      in   3   0 none,1 mult,2 multu,3 div,4 divu,5 mthi,6 mtlo
//   md_a       in   32  rs operand (post-forwarding)
//   md_b       in   32  rt operand (post-forwarding)
//   md_busy    out  1   multi-cycle op in flight
//   md_hi      out  32  HI register
//   md_lo      out  32  LO register
// BEHAVIOUR
// - Reset (asserted low, async): md_hi=0, md_lo=0, md_busy=0, counter=0,
//   shadow result regs=0. Reset mid-operation aborts it; no commit occurs.
// - Accept: at rising edge with md_start=1 and md_busy=0:
//   * ops 1-4: compute 64-bit result into shadow {s_hi,s_lo}; load counter
//     with MULT_CYCLES or DIV_CYCLES. md_busy=1 for exactly that many
//     cycles starting the cycle after accept.
//   * op 5: md_hi<=md_a next edge; op 6: md_lo<=md_a. No busy.
//   * op 0 or 7: no effect.
// - md_start=1 while md_busy=1: ignored entirely (hazard unit must stall).
// - Counter decrements every edge while nonzero; on the edge where it goes
//   1->0, {md_hi,md_lo}<={s_hi,s_lo}. md_busy = (counter!=0), registered-
//   equivalent (no combinational path from md_start to md_busy).
// - New op may be accepted on the same edge that clears busy? No: md_busy
//   is still 1 at that edge; earliest accept is the following edge.
// - Arithmetic:
//   * mult:  signed 32x32 -> {HI,LO} 64-bit product.
//   * multu: unsigned 32x32 -> {HI,LO}.
//   * div:   LO=quotient truncated toward zero, HI=remainder with sign of
//     dividend. 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
//   * divu:  unsigned LO=quotient, HI=remainder.
//   * divisor 0 (div/divu): busy runs full DIV_CYCLES, HI/LO unchanged
//     at commit (shadow loaded with current HI/LO).
// - HI/LO between accept and commit keep old values (mfhi reads old data
//   only if not stalled; stall policy lives in hazard unit).
// - States: IDLE(counter=0) -> RUN(counter=N..1) -> IDLE; commit on
//   RUN->IDLE. No other states.
// TESTING
// 1 mult a=0xFFFFFFFD(-3) b=5 -> busy high 5 cycles, then HI=0xFFFFFFFF,
//   LO=0xFFFFFFF1; HI/LO unchanged while busy.
// 2 multu a=0xFFFFFFFF b=2 -> after 5 cycles HI=0x00000001 LO=0xFFFFFFFE.
// 3 div a=0xFFFFFFF9(-7) b=2 -> busy 10 cycles, LO=0xFFFFFFFD HI=0xFFFFFFFF;
//   div 0x80000000/0xFFFFFFFF -> LO=0x80000000 HI=0.
// 4 divu a=7 b=0 with HI=0x11,LO=0x22 -> busy 10 cycles, HI=0x11 LO=0x22.
// 5 mult accepted, then md_start=1 op=mthi a=0xABCD at busy cycle 2 ->
//   ignored; HI ends with product; mthi after busy falls -> HI=0xABCD.
// 6 divu 100/7 accepted, reset low at busy cycle 4 -> busy=0, HI=LO=0
//   immediately (async); no commit after reset release.

Source files
------------

// File: rtl/md_unit.sv
// md_unit: execute-stage multiply/divide unit owning the HI/LO registers.
// Multi-cycle ops compute their 64-bit result at accept into shadow
// registers, then hold md_busy for a fixed latency before committing.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        md_start,
  input  logic [2:0]  md_op,
  input  logic [31:0] md_a,
  input  logic [31:0] md_b,
  output logic        md_busy,
  output logic [31:0] md_hi,
  output logic [31:0] md_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] MULT_N = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_N  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      s_hi_q, s_hi_d;
  logic [31:0]      s_lo_q, s_lo_d;

  // Signed 32x32 product; sign-extending to 64 bits keeps the low 64 bits exact.
  function automatic logic [63:0] mul_signed(input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] ax;
    logic signed [63:0] bx;
    logic signed [63:0] p;
    ax = {{32{a[31]}}, a};
    bx = {{32{b[31]}}, b};
    p  = ax * bx;
    return p;
  endfunction

  function automatic logic [63:0] mul_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax;
    logic [63:0] bx;
    ax = {32'd0, a};
    bx = {32'd0, b};
    return ax * bx;
  endfunction

  // Returns {remainder, quotient}; caller guarantees b != 0.
  function automatic logic [63:0] div_unsigned(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q;
    logic [31:0] r;
    q = a / b;
    r = a % b;
    return {r, q};
  endfunction

  // Truncating signed divide on magnitudes; remainder takes the dividend's
  // sign. 0x80000000 / -1 wraps back to 0x80000000 with remainder 0.
  function automatic logic [63:0] div_signed(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] q;
    logic [31:0] r;
    mag_a = a[31] ? (32'd0 - a) : a;
    mag_b = b[31] ? (32'd0 - b) : b;
    q = mag_a / mag_b;
    r = mag_a % mag_b;
    if (a[31] ^ b[31]) q = 32'd0 - q;
    if (a[31])         r = 32'd0 - r;
    return {r, q};
  endfunction

  // Next-state: accept new ops when idle, count down and commit when running.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    s_hi_d  = s_hi_q;
    s_lo_d  = s_lo_q;
    case (state_q)
      IDLE: begin
        if (md_start) begin
          case (md_op)
            OP_MULT: begin
              {s_hi_d, s_lo_d} = mul_signed(md_a, md_b);
              cnt_d   = MULT_N;
              state_d = RUN;
            end
            OP_MULTU: begin
              {s_hi_d, s_lo_d} = mul_unsigned(md_a, md_b);
              cnt_d   = MULT_N;
              state_d = RUN;
            end
            OP_DIV: begin
              if (md_b == 32'd0) {s_hi_d, s_lo_d} = {hi_q, lo_q};
              else               {s_hi_d, s_lo_d} = div_signed(md_a, md_b);
              cnt_d   = DIV_N;
              state_d = RUN;
            end
            OP_DIVU: begin
              if (md_b == 32'd0) {s_hi_d, s_lo_d} = {hi_q, lo_q};
              else               {s_hi_d, s_lo_d} = div_unsigned(md_a, md_b);
              cnt_d   = DIV_N;
              state_d = RUN;
            end
            OP_MTHI: hi_d = md_a;
            OP_MTLO: lo_d = md_a;
            default: ;
          endcase
        end
      end
      RUN: begin
        // md_start is ignored here; the hazard unit is expected to stall.
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          hi_d    = s_hi_q;
          lo_d    = s_lo_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counter, HI/LO and shadow registers; reset aborts any op in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      s_hi_q  <= 32'd0;
      s_lo_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      s_hi_q  <= s_hi_d;
      s_lo_q  <= s_lo_d;
    end
  end

  // Busy comes straight from the state register, so no path from md_start.
  always_comb begin
    md_busy = (state_q == RUN);
    md_hi   = hi_q;
    md_lo   = lo_q;
  end

endmodule
